exe_stage: RTL and testbench
============================

# exe_stage

Execute stage of the five-stage ARM-subset pipeline; it consumes the control bundle from the ID/EXE register (exe_cmd, mem_read_en, mem_write_en, wb_en, B, s) plus operands. It computes the ALU result and the NZCV flags, owns the architectural status register, and resolves branch targets. It also drives the EXE/MEM pipeline register.

## Interface
- DATA_W, 32, operand/result width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- freeze  in  1  memory-stage stall; holds all state
- valid_in  in  1  ID/EXE slot holds a real instruction (0 = bubble)
- exe_cmd  in  4  ALU operation (encoding below)
- mem_read_en, mem_write_en, wb_en, B, s  in  1 each  control bundle from ID/EXE
- val_rn  in  DATA_W  first operand
- val2  in  DATA_W  second operand (shifter output)
- val_rm  in  DATA_W  store data
- pc_in  in  DATA_W  PC of the instruction + 4
- imm24  in  24  branch offset
- dest_in  in  4  destination register
- branch_taken  out  1  combinational; redirect IF and flush IF/ID, ID/EXE
- branch_addr  out  DATA_W  combinational branch target
- status  out  4  registered {N,Z,C,V}; feeds the ID condition check
- alu_res_o, val_rm_o  out  DATA_W  EXE/MEM registered
- dest_o  out  4  EXE/MEM registered
- wb_en_o, mem_read_o, mem_write_o  out  1 each  EXE/MEM registered

## Operation
- The ALU takes a = val_rn, b = val2, and c = status C (current register value).
  - 0001 MOV: b.
  - 1001 MVN: ~b.
  - 0010 ADD: a+b.
  - 0011 ADC: a+b+c.
  - 0100 SUB: a−b.
  - 0101 SBC: a−b−(~c).
  - 0110 AND: a&b.
  - 0111 ORR: a|b.
  - 1000 EOR: a^b.
  - Any other code gives result 0 and flags_next = status.
- Arithmetic is computed at DATA_W+1 bits.
  - ADD/ADC: C = bit DATA_W (carry out); V = (a[31]==b[31]) & (r[31]!=a[31]).
  - SUB/SBC: C = NOT borrow; V = (a[31]!=b[31]) & (r[31]!=a[31]).
  - Logic ops and MOV/MVN: C and V are unchanged.
  - All ops: N = r[31], Z = (r==0).
- Status update: status <= flags_next only when valid_in & s & ~mem_read_en & ~mem_write_en & ~freeze. For LDR/STR, s selects load/store and never writes flags.
- branch_addr = pc_in + sign_extend(imm24) << 2, with 32-bit wrap-around.
- branch_taken = valid_in & B & ~freeze.
- EXE/MEM register, when ~freeze:
  - alu_res_o <= result; val_rm_o <= val_rm; dest_o <= dest_in.
  - wb_en_o <= valid_in & wb_en.
  - mem_read_o <= valid_in & mem_read_en.
  - mem_write_o <= valid_in & mem_write_en.
- A bubble (valid_in=0) registers all enables as 0, leaves status untouched, and produces no branch.
- CMP/TST arrive with wb_en=0 and s=1: flags update, no writeback.

## Timing
- Reset (asynchronous, any time): status=0000, every EXE/MEM output=0. Reset mid-operation discards the in-flight result.
- The first clk edge after rst deasserts captures normally.
- ALU/flags/branch path is combinational within one cycle.
- Result reaches the EXE/MEM outputs one clk edge later (latency 1).
- Status written at the edge is visible on `status` and to the next instruction's ADC/SBC carry in the following cycle; no flag bypass.
- freeze=1: EXE/MEM register and status hold their values; branch_taken=0. On release, the held instruction completes exactly once.
- Simultaneous B and s: both take effect. Flags update with that instruction's result.

## Test plan
- ADD, s=1, a=0x7FFFFFFF, b=1 → alu_res_o=0x80000000 next cycle; status=1001 (N=1, V=1).
- SUB, s=1, a=5, b=5 → result 0; status=0110 (Z=1, C=1 no borrow). Follow with SBC a=5, b=2 → result 3.
- ADC with C=1, a=0xFFFFFFFF, b=0 → result 0; status Z=1, C=1. Repeat with s=0 → status unchanged.
- LDR (mem_read_en=1, s=1, exe_cmd=0010) a=0x100, b=8 → alu_res_o=0x108, mem_read_o=1, status unchanged.
- B with pc_in=0x20, imm24=0xFFFFFE → branch_taken=1, branch_addr=0x18. Same with valid_in=0, or freeze=1 → branch_taken=0.
- Assert freeze for 3 cycles during an ADD, then assert rst mid-freeze → outputs hold during freeze; rst clears all outputs and status to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/exe_stage.sv
// exe_stage
//   Execute stage of the five-stage ARM-subset pipeline. Computes the ALU
//   result and NZCV flags, owns the architectural status register, resolves
//   branch targets and drives the EXE/MEM pipeline register.
//
// Ports
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   freeze             memory-stage stall; holds status and EXE/MEM state
//   valid_in           ID/EXE slot holds a real instruction (0 = bubble)
//   exe_cmd            ALU operation
//   mem_read_en, mem_write_en, wb_en, B, s   control bundle from ID/EXE
//   val_rn, val2       ALU operands (val2 is the shifter output)
//   val_rm             store data, forwarded to EXE/MEM
//   pc_in, imm24       PC+4 and branch offset for target computation
//   dest_in            destination register
//   branch_taken       combinational redirect / flush request
//   branch_addr        combinational branch target
//   status             registered {N,Z,C,V}
//   alu_res_o, val_rm_o, dest_o, wb_en_o, mem_read_o, mem_write_o
//                      EXE/MEM register outputs
module exe_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              valid_in,
    input  logic [3:0]        exe_cmd,
    input  logic              mem_read_en,
    input  logic              mem_write_en,
    input  logic              wb_en,
    input  logic              B,
    input  logic              s,
    input  logic [DATA_W-1:0] val_rn,
    input  logic [DATA_W-1:0] val2,
    input  logic [DATA_W-1:0] val_rm,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [23:0]       imm24,
    input  logic [3:0]        dest_in,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_addr,
    output logic [3:0]        status,
    output logic [DATA_W-1:0] alu_res_o,
    output logic [DATA_W-1:0] val_rm_o,
    output logic [3:0]        dest_o,
    output logic              wb_en_o,
    output logic              mem_read_o,
    output logic              mem_write_o
);

    localparam int MSB = DATA_W - 1;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;

    logic [DATA_W-1:0] result;
    logic [DATA_W:0]   sum;
    logic [3:0]        flags_next;
    logic              known_op;
    logic              carry_in;
    logic              flag_write;
    logic [DATA_W-1:0] branch_offset;

    assign carry_in = status[1];

    // ALU and flag generation. Arithmetic runs one bit wider than the data
    // path so the top bit is the carry (add) or borrow (subtract). Logic ops
    // leave C and V at their current values; unknown codes leave all flags.
    always_comb begin
        result     = '0;
        sum        = '0;
        flags_next = status;
        known_op   = 1'b1;
        case (exe_cmd)
            CMD_MOV: result = val2;
            CMD_MVN: result = ~val2;
            CMD_AND: result = val_rn & val2;
            CMD_ORR: result = val_rn | val2;
            CMD_EOR: result = val_rn ^ val2;
            CMD_ADD, CMD_ADC: begin
                sum = {1'b0, val_rn} + {1'b0, val2}
                    + {{DATA_W{1'b0}}, (exe_cmd == CMD_ADC) & carry_in};
                result        = sum[MSB:0];
                flags_next[1] = sum[DATA_W];
                flags_next[0] = (val_rn[MSB] == val2[MSB]) & (result[MSB] != val_rn[MSB]);
            end
            CMD_SUB, CMD_SBC: begin
                // SBC subtracts the inverted carry, so C=1 means "no borrow".
                sum = {1'b0, val_rn} - {1'b0, val2}
                    - {{DATA_W{1'b0}}, (exe_cmd == CMD_SBC) & ~carry_in};
                result        = sum[MSB:0];
                flags_next[1] = ~sum[DATA_W];
                flags_next[0] = (val_rn[MSB] != val2[MSB]) & (result[MSB] != val_rn[MSB]);
            end
            default: known_op = 1'b0;
        endcase
        if (known_op) begin
            flags_next[3] = result[MSB];
            flags_next[2] = (result == '0);
        end
    end

    // Loads and stores reuse s as a load/store selector, so they must never
    // touch the flags even when s is set.
    assign flag_write = valid_in & s & ~mem_read_en & ~mem_write_en & ~freeze;

    // Branch target: word offset sign-extended and scaled by four.
    assign branch_offset = {{(DATA_W-26){imm24[23]}}, imm24, 2'b00};
    assign branch_addr   = pc_in + branch_offset;
    assign branch_taken  = valid_in & B & ~freeze;

    // Architectural status register; a freeze or bubble leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status <= 4'b0000;
        end else if (flag_write) begin
            status <= flags_next;
        end
    end

    // EXE/MEM pipeline register. Enables are qualified with valid_in so a
    // bubble travels down the pipe as a no-op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_res_o   <= '0;
            val_rm_o    <= '0;
            dest_o      <= 4'd0;
            wb_en_o     <= 1'b0;
            mem_read_o  <= 1'b0;
            mem_write_o <= 1'b0;
        end else if (!freeze) begin
            alu_res_o   <= result;
            val_rm_o    <= val_rm;
            dest_o      <= dest_in;
            wb_en_o     <= valid_in & wb_en;
            mem_read_o  <= valid_in & mem_read_en;
            mem_write_o <= valid_in & mem_write_en;
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage
//   Self-checking bench for exe_stage. Directed scenarios plus a randomized
//   run, all compared against a behavioural model that computes results and
//   flags with 64-bit integer arithmetic.
module tb_exe_stage;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        valid_in;
    logic [3:0]  exe_cmd;
    logic        mem_read_en;
    logic        mem_write_en;
    logic        wb_en;
    logic        B;
    logic        s;
    logic [31:0] val_rn;
    logic [31:0] val2;
    logic [31:0] val_rm;
    logic [31:0] pc_in;
    logic [23:0] imm24;
    logic [3:0]  dest_in;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [3:0]  status;
    logic [31:0] alu_res_o;
    logic [31:0] val_rm_o;
    logic [3:0]  dest_o;
    logic        wb_en_o;
    logic        mem_read_o;
    logic        mem_write_o;

    int checks   = 0;
    int failures = 0;

    // Model state: what the EXE/MEM register and status should hold.
    logic [31:0] exp_alu;
    logic [31:0] exp_rm;
    logic [3:0]  exp_dest;
    logic [2:0]  exp_en;
    logic [3:0]  exp_status;

    exe_stage #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .valid_in     (valid_in),
        .exe_cmd      (exe_cmd),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .wb_en        (wb_en),
        .B            (B),
        .s            (s),
        .val_rn       (val_rn),
        .val2         (val2),
        .val_rm       (val_rm),
        .pc_in        (pc_in),
        .imm24        (imm24),
        .dest_in      (dest_in),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .status       (status),
        .alu_res_o    (alu_res_o),
        .val_rm_o     (val_rm_o),
        .dest_o       (dest_o),
        .wb_en_o      (wb_en_o),
        .mem_read_o   (mem_read_o),
        .mem_write_o  (mem_write_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference ALU: true integer sums/differences, carry from magnitude,
    // overflow from whether the signed result fits in 32 bits.
    task automatic model_alu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] st, output logic [31:0] r, output logic [3:0] f);
        longint ua, ub, us, sa, sb, ss, extra;
        bit known;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        f = st;
        r = 32'd0;
        known = 1'b1;
        case (cmd)
            4'd1: r = b;
            4'd9: r = ~b;
            4'd6: r = a & b;
            4'd7: r = a | b;
            4'd8: r = a ^ b;
            4'd2, 4'd3: begin
                extra = (cmd == 4'd3 && st[1]) ? 64'd1 : 64'd0;
                us = ua + ub + extra;
                ss = sa + sb + extra;
                r = us[31:0];
                f[1] = (us > 64'h0000_0000_FFFF_FFFF);
                f[0] = (ss != longint'($signed(r)));
            end
            4'd4, 4'd5: begin
                extra = (cmd == 4'd5 && !st[1]) ? 64'd1 : 64'd0;
                us = ua - ub - extra;
                ss = sa - sb - extra;
                r = us[31:0];
                f[1] = (ua >= ub + extra);
                f[0] = (ss != longint'($signed(r)));
            end
            default: known = 1'b0;
        endcase
        if (known) begin
            f[3] = r[31];
            f[2] = (r == 32'd0);
        end
    endtask

    task automatic model_reset();
        exp_alu    = 32'd0;
        exp_rm     = 32'd0;
        exp_dest   = 4'd0;
        exp_en     = 3'b000;
        exp_status = 4'b0000;
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        logic [31:0] r;
        logic [3:0]  f;
        model_alu(exe_cmd, val_rn, val2, exp_status, r, f);
        if (!freeze) begin
            exp_alu  = r;
            exp_rm   = val_rm;
            exp_dest = dest_in;
            exp_en   = {valid_in & wb_en, valid_in & mem_read_en, valid_in & mem_write_en};
            if (valid_in && s && !mem_read_en && !mem_write_en) exp_status = f;
        end
    endtask

    function automatic logic [31:0] model_baddr(input logic [31:0] pc, input logic [23:0] imm);
        int off;
        off = int'($signed(imm)) * 4;
        return pc + 32'(off);
    endfunction

    task automatic set_alu(input logic v, input logic [3:0] cmd, input logic sf, input logic wb,
                           input logic [31:0] a, input logic [31:0] b);
        valid_in     = v;
        exe_cmd      = cmd;
        s            = sf;
        wb_en        = wb;
        val_rn       = a;
        val2         = b;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        B            = 1'b0;
        freeze       = 1'b0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'(($urandom_range(0, 15)));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (alu_res_o !== 32'd0) begin failures++; $display("[TB] FAIL reset_alu: got %h expected %h", alu_res_o, 32'd0); end
        checks++;
        if (val_rm_o !== 32'd0) begin failures++; $display("[TB] FAIL reset_rm: got %h expected %h", val_rm_o, 32'd0); end
        checks++;
        if ({dest_o, wb_en_o, mem_read_o, mem_write_o} !== 7'd0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: got %b expected %b", {dest_o, wb_en_o, mem_read_o, mem_write_o}, 7'd0);
        end
        checks++;
        if (status !== 4'b0000) begin failures++; $display("[TB] FAIL reset_status: got %b expected %b", status, 4'b0000); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_arith();
        // ADD overflow into the sign bit; first edge after reset release
        @(negedge clk);
        set_alu(1'b1, 4'b0010, 1'b1, 1'b1, 32'h7FFF_FFFF, 32'd1);
        dest_in = 4'd3;
        val_rm  = 32'hDEAD_BEEF;
        tick();
        checks++;
        if (alu_res_o !== 32'h8000_0000) begin failures++; $display("[TB] FAIL add_ovf_res: got %h expected %h", alu_res_o, 32'h8000_0000); end
        checks++;
        if (status !== 4'b1001) begin failures++; $display("[TB] FAIL add_ovf_status: got %b expected %b", status, 4'b1001); end
        checks++;
        if ({dest_o, wb_en_o, val_rm_o} !== {4'd3, 1'b1, 32'hDEAD_BEEF}) begin
            failures++;
            $display("[TB] FAIL add_pass: got %h/%b/%h expected 3/1/deadbeef", dest_o, wb_en_o, val_rm_o);
        end
        // SUB equal operands: zero, no borrow
        @(negedge clk);
        set_alu(1'b1, 4'b0100, 1'b1, 1'b1, 32'd5, 32'd5);
        tick();
        checks++;
        if ({alu_res_o, status} !== {32'd0, 4'b0110}) begin
            failures++;
            $display("[TB] FAIL sub_eq: got %h/%b expected %h/%b", alu_res_o, status, 32'd0, 4'b0110);
        end
        // SBC with C=1 subtracts nothing extra
        @(negedge clk);
        set_alu(1'b1, 4'b0101, 1'b1, 1'b1, 32'd5, 32'd2);
        tick();
        checks++;
        if ({alu_res_o, status} !== {32'd3, 4'b0010}) begin
            failures++;
            $display("[TB] FAIL sbc_c1: got %h/%b expected %h/%b", alu_res_o, status, 32'd3, 4'b0010);
        end
        // ADC with C=1 wraps to zero with carry out
        @(negedge clk);
        set_alu(1'b1, 4'b0011, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd0);
        tick();
        checks++;
        if ({alu_res_o, status} !== {32'd0, 4'b0110}) begin
            failures++;
            $display("[TB] FAIL adc_wrap: got %h/%b expected %h/%b", alu_res_o, status, 32'd0, 4'b0110);
        end
        // ADC with s=0: carry still consumed, flags untouched
        @(negedge clk);
        set_alu(1'b1, 4'b0011, 1'b0, 1'b1, 32'd1, 32'd1);
        tick();
        checks++;
        if ({alu_res_o, status} !== {32'd3, 4'b0110}) begin
            failures++;
            $display("[TB] FAIL adc_nos: got %h/%b expected %h/%b", alu_res_o, status, 32'd3, 4'b0110);
        end
        // CMP: flags update, no writeback
        @(negedge clk);
        set_alu(1'b1, 4'b0100, 1'b1, 1'b0, 32'd3, 32'd5);
        tick();
        checks++;
        if ({alu_res_o, status, wb_en_o} !== {32'hFFFF_FFFE, 4'b1000, 1'b0}) begin
            failures++;
            $display("[TB] FAIL cmp: got %h/%b/%b expected fffffffe/1000/0", alu_res_o, status, wb_en_o);
        end
    endtask

    task automatic test_load();
        @(negedge clk);
        set_alu(1'b1, 4'b0010, 1'b1, 1'b1, 32'h100, 32'd8);
        mem_read_en = 1'b1;
        tick();
        checks++;
        if ({alu_res_o, mem_read_o, mem_write_o} !== {32'h108, 1'b1, 1'b0}) begin
            failures++;
            $display("[TB] FAIL ldr: got %h/%b/%b expected 108/1/0", alu_res_o, mem_read_o, mem_write_o);
        end
        checks++;
        if (status !== 4'b1000) begin failures++; $display("[TB] FAIL ldr_status: got %b expected %b", status, 4'b1000); end
    endtask

    task automatic test_branch();
        @(negedge clk);
        set_alu(1'b1, 4'b0100, 1'b1, 1'b0, 32'd1, 32'd1);
        B     = 1'b1;
        pc_in = 32'h20;
        imm24 = 24'hFFFFFE;
        #1;
        checks++;
        if ({branch_taken, branch_addr} !== {1'b1, 32'h18}) begin
            failures++;
            $display("[TB] FAIL branch: got %b/%h expected 1/18", branch_taken, branch_addr);
        end
        valid_in = 1'b0;
        #1;
        checks++;
        if (branch_taken !== 1'b0) begin failures++; $display("[TB] FAIL branch_bubble: got %b expected 0", branch_taken); end
        valid_in = 1'b1;
        freeze   = 1'b1;
        #1;
        checks++;
        if (branch_taken !== 1'b0) begin failures++; $display("[TB] FAIL branch_freeze: got %b expected 0", branch_taken); end
        // Branch together with s: flags still update
        freeze = 1'b0;
        tick();
        checks++;
        if ({alu_res_o, status} !== {32'd0, 4'b0110}) begin
            failures++;
            $display("[TB] FAIL branch_s: got %h/%b expected 0/0110", alu_res_o, status);
        end
        // Bubble: enables zero, status untouched
        @(negedge clk);
        set_alu(1'b0, 4'b0100, 1'b1, 1'b1, 32'd1, 32'd2);
        mem_write_en = 1'b1;
        tick();
        checks++;
        if ({wb_en_o, mem_read_o, mem_write_o, status} !== {3'b000, 4'b0110}) begin
            failures++;
            $display("[TB] FAIL bubble: got %b/%b expected 000/0110", {wb_en_o, mem_read_o, mem_write_o}, status);
        end
    endtask

    task automatic test_freeze_reset();
        @(negedge clk);
        set_alu(1'b1, 4'b0010, 1'b1, 1'b1, 32'd3, 32'd4);
        dest_in = 4'd5;
        val_rm  = 32'h1234_5678;
        tick();
        @(negedge clk);
        set_alu(1'b1, 4'b0100, 1'b1, 1'b1, 32'd1, 32'd2);
        dest_in = 4'd9;
        val_rm  = 32'hCAFE_F00D;
        freeze  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({alu_res_o, val_rm_o, dest_o, wb_en_o, status} !== {32'd7, 32'h1234_5678, 4'd5, 1'b1, 4'b0000}) begin
                failures++;
                $display("[TB] FAIL freeze_hold: got %h/%h/%h/%b/%b expected 7/12345678/5/1/0000",
                         alu_res_o, val_rm_o, dest_o, wb_en_o, status);
            end
        end
        // Asynchronous reset in the middle of a cycle, while still frozen
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({alu_res_o, val_rm_o, dest_o, wb_en_o, mem_read_o, mem_write_o, status} !== 75'd0) begin
            failures++;
            $display("[TB] FAIL async_reset: got %h/%h/%h/%b/%b expected all zero",
                     alu_res_o, val_rm_o, dest_o, {wb_en_o, mem_read_o, mem_write_o}, status);
        end
        model_reset();
        @(negedge clk);
        rst    = 1'b0;
        freeze = 1'b0;
        tick();
        checks++;
        if ({alu_res_o, dest_o, wb_en_o, status} !== {32'hFFFF_FFFF, 4'd9, 1'b1, 4'b1000}) begin
            failures++;
            $display("[TB] FAIL release: got %h/%h/%b/%b expected ffffffff/9/1/1000", alu_res_o, dest_o, wb_en_o, status);
        end
        @(negedge clk);
        valid_in = 1'b0;
        tick();
        checks++;
        if ({wb_en_o, status} !== {1'b0, 4'b1000}) begin
            failures++;
            $display("[TB] FAIL once: got %b/%b expected 0/1000", wb_en_o, status);
        end
    endtask

    task automatic test_random();
        logic        exp_taken;
        logic [31:0] exp_baddr;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            valid_in     = ($urandom_range(0, 5) != 0);
            exe_cmd      = 4'($urandom_range(0, 15));
            s            = 1'($urandom_range(0, 1));
            wb_en        = 1'($urandom_range(0, 1));
            mem_read_en  = ($urandom_range(0, 7) == 0);
            mem_write_en = !mem_read_en && ($urandom_range(0, 7) == 0);
            B            = ($urandom_range(0, 3) == 0);
            freeze       = ($urandom_range(0, 7) == 0);
            val_rn       = pick_val();
            val2         = pick_val();
            val_rm       = $urandom;
            pc_in        = $urandom;
            imm24        = 24'($urandom);
            dest_in      = 4'($urandom_range(0, 15));
            #1;
            exp_taken = valid_in & B & ~freeze;
            exp_baddr = model_baddr(pc_in, imm24);
            checks++;
            if (branch_taken !== exp_taken) begin
                failures++;
                $display("[TB] FAIL rnd_taken[%0d]: got %b expected %b", n, branch_taken, exp_taken);
            end
            checks++;
            if (branch_addr !== exp_baddr) begin
                failures++;
                $display("[TB] FAIL rnd_baddr[%0d]: got %h expected %h", n, branch_addr, exp_baddr);
            end
            tick();
            checks++;
            if (alu_res_o !== exp_alu) begin
                failures++;
                $display("[TB] FAIL rnd_alu[%0d] cmd=%h: got %h expected %h", n, exe_cmd, alu_res_o, exp_alu);
            end
            checks++;
            if (status !== exp_status) begin
                failures++;
                $display("[TB] FAIL rnd_status[%0d] cmd=%h: got %b expected %b", n, exe_cmd, status, exp_status);
            end
            checks++;
            if ({val_rm_o, dest_o} !== {exp_rm, exp_dest}) begin
                failures++;
                $display("[TB] FAIL rnd_pass[%0d]: got %h/%h expected %h/%h", n, val_rm_o, dest_o, exp_rm, exp_dest);
            end
            checks++;
            if ({wb_en_o, mem_read_o, mem_write_o} !== exp_en) begin
                failures++;
                $display("[TB] FAIL rnd_en[%0d]: got %b expected %b", n, {wb_en_o, mem_read_o, mem_write_o}, exp_en);
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        freeze       = 1'b0;
        valid_in     = 1'b0;
        exe_cmd      = 4'd0;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        wb_en        = 1'b0;
        B            = 1'b0;
        s            = 1'b0;
        val_rn       = 32'd0;
        val2         = 32'd0;
        val_rm       = 32'd0;
        pc_in        = 32'd0;
        imm24        = 24'd0;
        dest_in      = 4'd0;
        model_reset();
        test_reset();
        test_arith();
        test_load();
        test_branch();
        test_freeze_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
